// File: rtl/ibex_data_bus_responder.sv
// ibex_data_bus_responder: RAM-backed data bus target with configurable grant delay and in-order response latency
module ibex_data_bus_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RSP_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        busy_o
);
  localparam int L = int'(RSP_LATENCY);
  localparam int unsigned AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned WW = GNT_DELAY > 0 ? $clog2(GNT_DELAY + 1) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [WW-1:0] GD = WW'(GNT_DELAY);
  localparam logic [OW-1:0] MO = OW'(MAX_OUTSTANDING);
  logic [31:0] mem_q [MEM_WORDS];
  logic [WW-1:0] wait_q, wait_d;
  logic [OW-1:0] out_q, out_d;
  logic [L-1:0] vld_q, err_q;
  logic [L-1:0][31:0] rdata_q;
  logic [29:0] widx;
  logic [AW-1:0] idx;
  logic addr_err, gnt, rvalid;
  // The subtraction wraps for addresses below the base, so the explicit compare catches those
  assign widx = 30'((data_addr_i - BASE_ADDR) >> 2);
  assign idx = widx[AW-1:0];
  assign addr_err = (data_addr_i < BASE_ADDR) | ({2'b00, widx} >= MEM_WORDS);
  assign gnt = data_req_i & (wait_q == GD) & (out_q < MO);
  assign rvalid = vld_q[L-1];
  assign data_gnt_o = gnt;
  assign data_rvalid_o = rvalid;
  assign data_err_o = rvalid & err_q[L-1];
  assign data_rdata_o = rvalid ? rdata_q[L-1] : '0;
  assign busy_o = out_q != '0;
  // Next-state for the grant wait counter and the outstanding-transaction count
  always_comb begin
    wait_d = (gnt | ~data_req_i) ? '0 : (wait_q == GD) ? wait_q : wait_q + 1'b1;
    out_d = (gnt & ~rvalid) ? out_q + 1'b1 : (~gnt & rvalid) ? out_q - 1'b1 : out_q;
  end
  // Handshake counters
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wait_q <= '0;
      out_q <= '0;
    end else begin
      wait_q <= wait_d;
      out_q <= out_d;
    end
  // Response pipeline: stage 0 captures the granted transaction, the last stage drives the bus
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
    end else begin
      vld_q[0] <= gnt;
      err_q[0] <= gnt & addr_err;
      rdata_q[0] <= (gnt & ~data_we_i & ~addr_err) ? mem_q[idx] : '0;
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk_i)
    if (gnt & data_we_i & ~addr_err)
      for (int b = 0; b < 4; b++)
        if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
endmodule

// File: tb/tb_ibex_data_bus_responder.sv
// tb_ibex_data_bus_responder: directed and randomized checks of the data bus responder across three configurations
module tb_ibex_data_bus_responder;
  localparam logic [31:0] W0 = 32'h0BAD_0001;
  localparam logic [31:0] W1 = 32'h0BAD_0002;
  localparam logic [31:0] W2 = 32'h0BAD_0003;
  typedef struct {int due; logic e; logic [31:0] d;} rsp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] req = '0;
  logic [2:0] we = '0;
  logic [2:0][31:0] addr = '0;
  logic [2:0][31:0] wdata = '0;
  logic [2:0][3:0] be = '0;
  wire [2:0] gnt, rvalid, err, busy;
  wire [2:0][31:0] rdata;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  ibex_data_bus_responder u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_err_o(err[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]), .busy_o(busy[0]));
  ibex_data_bus_responder #(.GNT_DELAY(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_err_o(err[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]), .busy_o(busy[1]));
  ibex_data_bus_responder #(.BASE_ADDR(32'h1000), .MEM_WORDS(16), .RSP_LATENCY(2), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_rvalid_o(rvalid[2]), .data_err_o(err[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]), .busy_o(busy[2]));
  // One transaction on port k: cycles waited for grant, grant-to-rvalid latency (-1 on timeout), response fields.
  // Starts and ends just after a rising edge.
  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                      output int gw, output int lat, output logic e, output logic [31:0] rd);
    req[k] = 1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    gw = -1; lat = -1; e = 1'bx; rd = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[k]) begin gw = i; break; end
    end
    @(posedge clk); #1;
    req[k] = 0;
    if (gw < 0) return;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (rvalid[k]) begin lat = i; e = err[k]; rd = rdata[k]; break; end
      @(posedge clk); #1;
    end
    if (lat > 0) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset();
    rst_n = 0; req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 3'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (rvalid !== 3'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
    checks++; if (err !== 3'b0) begin errors++; $display("FAIL reset_err: got %b expected 000", err); end
    checks++; if (busy !== 3'b0) begin errors++; $display("FAIL reset_busy: got %b expected 000", busy); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_defaults();
    int gw, lat; logic e; logic [31:0] rd;
    xact(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, gw, lat, e, rd);
    checks++; if (gw != 0) begin errors++; $display("FAIL def_wr_gnt_wait: got %0d expected 0", gw); end
    checks++; if (lat != 1) begin errors++; $display("FAIL def_wr_latency: got %0d expected 1", lat); end
    checks++; if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL def_wr_rsp: got err=%b rdata=%h expected 0/0", e, rd); end
    xact(0, 0, 32'h10, 4'h0, 32'h0, gw, lat, e, rd);
    checks++; if (lat != 1) begin errors++; $display("FAIL def_rd_latency: got %0d expected 1", lat); end
    checks++; if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL def_rd_rsp: got err=%b rdata=%h expected 0/deadbeef", e, rd); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL def_busy_idle: got %b expected 0", busy[0]); end
  endtask
  task automatic test_back_to_back();
    req[0] = 1; we[0] = 1; addr[0] = 32'h40; be[0] = 4'hF; wdata[0] = 32'h12345678;
    @(negedge clk);
    checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL b2b_wr_gnt: got %b expected 1", gnt[0]); end
    @(posedge clk); #1;
    we[0] = 0; be[0] = 4'h1;
    @(negedge clk);
    checks++; if (gnt[0] !== 1'b1 || rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin errors++; $display("FAIL b2b_rd_gnt: got gnt=%b rvalid=%b rdata=%h expected 1/1/0", gnt[0], rvalid[0], rdata[0]); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy[0]); end
    @(posedge clk); #1;
    req[0] = 0;
    @(negedge clk);
    checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h12345678) begin errors++; $display("FAIL b2b_rd_data: got rvalid=%b rdata=%h expected 1/12345678", rvalid[0], rdata[0]); end
    @(posedge clk); #1;
  endtask
  task automatic test_byte_enables();
    int gw, lat; logic e; logic [31:0] rd;
    xact(0, 1, 32'h20, 4'hF, 32'h11223344, gw, lat, e, rd);
    xact(0, 1, 32'h20, 4'b0110, 32'hAABBCCDD, gw, lat, e, rd);
    checks++; if (lat != 1 || e !== 1'b0) begin errors++; $display("FAIL be_partial_rsp: got lat=%0d err=%b expected 1/0", lat, e); end
    xact(0, 0, 32'h20, 4'b0001, 32'h0, gw, lat, e, rd);
    checks++; if (rd !== 32'h11BBCC44) begin errors++; $display("FAIL be_partial_read: got %h expected 11bbcc44", rd); end
    xact(0, 1, 32'h22, 4'b0000, 32'hFFFFFFFF, gw, lat, e, rd);
    checks++; if (lat != 1 || e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL be_zero_rsp: got lat=%0d err=%b rdata=%h expected 1/0/0", lat, e, rd); end
    xact(0, 0, 32'h20, 4'h0, 32'h0, gw, lat, e, rd);
    checks++; if (rd !== 32'h11BBCC44) begin errors++; $display("FAIL be_zero_read: got %h expected 11bbcc44", rd); end
  endtask
  task automatic test_gnt_delay();
    int gw, lat; logic e; logic [31:0] rd; logic early;
    xact(1, 1, 32'h80, 4'hF, 32'hCAFEF00D, gw, lat, e, rd);
    checks++; if (gw != 2) begin errors++; $display("FAIL gd_held_wait: got %0d expected 2", gw); end
    checks++; if (lat != 1) begin errors++; $display("FAIL gd_latency: got %0d expected 1", lat); end
    req[1] = 1; we[1] = 0; addr[1] = 32'h80;
    @(negedge clk); early = gnt[1];
    @(posedge clk); #1; req[1] = 0;
    @(negedge clk); early |= gnt[1];
    @(posedge clk); #1;
    @(negedge clk); early |= gnt[1];
    @(posedge clk); #1; req[1] = 1;
    gw = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt[1]) begin gw = i; break; end
      @(posedge clk); #1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL gd_early_gnt: got %b expected 0", early); end
    checks++; if (gw != 2) begin errors++; $display("FAIL gd_restart_cycle: got %0d expected 5", gw + 3); end
    @(posedge clk); #1; req[1] = 0;
    @(negedge clk);
    checks++; if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL gd_read: got rvalid=%b rdata=%h expected 1/cafef00d", rvalid[1], rdata[1]); end
    @(posedge clk); #1;
  endtask
  task automatic test_errors();
    int gw, lat; logic e; logic [31:0] rd;
    xact(2, 1, 32'h1000, 4'hF, 32'hA5A50000, gw, lat, e, rd);
    checks++; if (lat != 2 || e !== 1'b0) begin errors++; $display("FAIL err_pre_wr: got lat=%0d err=%b expected 2/0", lat, e); end
    xact(2, 1, 32'h103C, 4'hF, 32'h5A5A000F, gw, lat, e, rd);
    xact(2, 0, 32'h0FFC, 4'hF, 32'h0, gw, lat, e, rd);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_below_read: got err=%b rdata=%h expected 1/0", e, rd); end
    xact(2, 1, 32'h1040, 4'hF, 32'hFFFFFFFF, gw, lat, e, rd);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_above_write: got err=%b expected 1", e); end
    xact(2, 1, 32'h0FFC, 4'hF, 32'hFFFFFFFF, gw, lat, e, rd);
    checks++; if (e !== 1'b1 || lat != 2) begin errors++; $display("FAIL err_below_write: got err=%b lat=%0d expected 1/2", e, lat); end
    xact(2, 0, 32'h1000, 4'hF, 32'h0, gw, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'hA5A50000) begin errors++; $display("FAIL err_word0_intact: got err=%b rdata=%h expected 0/a5a50000", e, rd); end
    xact(2, 0, 32'h103C, 4'hF, 32'h0, gw, lat, e, rd);
    checks++; if (e !== 1'b0 || rd !== 32'h5A5A000F) begin errors++; $display("FAIL err_last_word: got err=%b rdata=%h expected 0/5a5a000f", e, rd); end
  endtask
  task automatic test_split();
    int gw, lat; logic e; logic [31:0] rd;
    xact(2, 1, 32'h1000, 4'hF, W0, gw, lat, e, rd);
    xact(2, 1, 32'h1004, 4'hF, W1, gw, lat, e, rd);
    xact(2, 1, 32'h1008, 4'hF, W2, gw, lat, e, rd);
    req[2] = 1; we[2] = 0; addr[2] = 32'h1000;
    @(negedge clk);
    checks++; if (gnt[2] !== 1'b1) begin errors++; $display("FAIL split_gnt0: got %b expected 1", gnt[2]); end
    @(posedge clk); #1; addr[2] = 32'h1004;
    @(negedge clk);
    checks++; if (gnt[2] !== 1'b1 || rvalid[2] !== 1'b0) begin errors++; $display("FAIL split_gnt1: got gnt=%b rvalid=%b expected 1/0", gnt[2], rvalid[2]); end
    @(posedge clk); #1; addr[2] = 32'h1008;
    @(negedge clk);
    checks++; if (gnt[2] !== 1'b0) begin errors++; $display("FAIL split_stall: got gnt=%b expected 0", gnt[2]); end
    checks++; if (rvalid[2] !== 1'b1 || rdata[2] !== W0) begin errors++; $display("FAIL split_rsp0: got rvalid=%b rdata=%h expected 1/%h", rvalid[2], rdata[2], W0); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (gnt[2] !== 1'b1) begin errors++; $display("FAIL split_gnt2: got %b expected 1", gnt[2]); end
    checks++; if (rvalid[2] !== 1'b1 || rdata[2] !== W1) begin errors++; $display("FAIL split_rsp1: got rvalid=%b rdata=%h expected 1/%h", rvalid[2], rdata[2], W1); end
    @(posedge clk); #1; req[2] = 0;
    @(negedge clk);
    checks++; if (rvalid[2] !== 1'b0 || busy[2] !== 1'b1) begin errors++; $display("FAIL split_gap: got rvalid=%b busy=%b expected 0/1", rvalid[2], busy[2]); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rvalid[2] !== 1'b1 || rdata[2] !== W2) begin errors++; $display("FAIL split_rsp2: got rvalid=%b rdata=%h expected 1/%h", rvalid[2], rdata[2], W2); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL split_drain: got busy=%b expected 0", busy[2]); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    int gw, lat; logic e; logic [31:0] rd; logic seen, g;
    req[2] = 1; we[2] = 0; addr[2] = 32'h1004;
    @(negedge clk); g = gnt[2];
    @(posedge clk); #1; addr[2] = 32'h1008;
    @(negedge clk); g &= gnt[2];
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL rstmid_grants: got %b expected 1", g); end
    @(posedge clk); #1;
    req[2] = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      seen |= rvalid[2];
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_stale_rvalid: got %b expected 0", seen); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy[2]); end
    @(posedge clk); #1;
    xact(2, 0, 32'h1004, 4'hF, 32'h0, gw, lat, e, rd);
    checks++; if (lat != 2 || rd !== W1) begin errors++; $display("FAIL rstmid_ram_kept: got lat=%0d rdata=%h expected 2/%h", lat, rd, W1); end
  endtask
  task automatic test_random();
    rsp_t q[$];
    rsp_t n;
    logic [31:0] mm [8];
    int gw, lat, wi;
    logic r, w, e, eg, erv, e2;
    logic [31:0] a, d, rd;
    logic [3:0] b;
    for (int i = 0; i < 8; i++) begin
      mm[i] = $urandom;
      xact(0, 1, 32'h200 + 32'(i * 4), 4'hF, mm[i], gw, lat, e2, rd);
    end
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 3) != 0;
      w = 1'($urandom_range(0, 1));
      wi = $urandom_range(0, 8);
      a = wi == 8 ? 32'h1000 + 32'($urandom_range(0, 4095)) : 32'h200 + 32'(wi * 4) + 32'($urandom_range(0, 3));
      e = (a >> 2) >= 1024;
      b = 4'($urandom);
      d = $urandom;
      req[0] = r; we[0] = w; addr[0] = a; be[0] = b; wdata[0] = d;
      @(negedge clk);
      eg = r && q.size() < 2;
      erv = q.size() != 0 && q[0].due == c;
      checks++; if (gnt[0] !== eg) begin errors++; $display("FAIL rnd_gnt c=%0d: got %b expected %b", c, gnt[0], eg); end
      checks++; if (rvalid[0] !== erv) begin errors++; $display("FAIL rnd_rvalid c=%0d: got %b expected %b", c, rvalid[0], erv); end
      checks++; if (busy[0] !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy[0], q.size() != 0); end
      if (erv) begin
        checks++; if (err[0] !== q[0].e || rdata[0] !== q[0].d) begin errors++; $display("FAIL rnd_rsp c=%0d: got err=%b rdata=%h expected %b/%h", c, err[0], rdata[0], q[0].e, q[0].d); end
        void'(q.pop_front());
      end else begin
        checks++; if (err[0] !== 1'b0 || rdata[0] !== 32'h0) begin errors++; $display("FAIL rnd_idle c=%0d: got err=%b rdata=%h expected 0/0", c, err[0], rdata[0]); end
      end
      if (eg) begin
        n.due = c + 1; n.e = e; n.d = (!w && !e) ? mm[wi % 8] : 32'h0;
        q.push_back(n);
        if (w && !e)
          for (int k = 0; k < 4; k++) if (b[k]) mm[wi][8*k +: 8] = d[8*k +: 8];
      end
      @(posedge clk); #1;
    end
    req[0] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rnd_drain: got busy=%b expected 0", busy[0]); end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_defaults();
    test_back_to_back();
    test_byte_enables();
    test_gnt_delay();
    test_errors();
    test_split();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
